// File: rtl/qspi_mgmt_bridge.sv
`timescale 1ns/1ps
// Quad-SPI device-side bridge onto the management register bus.
// Pins are oversampled in clk; word bit 15 selects read (1) or write (0), reads prefetch one byte ahead.
module qspi_mgmt_bridge #(
  parameter int DUMMY_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        qspi_sck,
  input  logic        qspi_cs_n,
  input  logic [3:0]  qspi_dq_in,
  output logic [3:0]  qspi_dq_out,
  output logic        qspi_dq_oe,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        read_underrun
);

  typedef enum logic [2:0] {IDLE, ADDR, WRITE_DATA, DUMMY, READ_DATA} state_t;

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [3:0]             dq_sync [SYNC_STAGES];
  logic                   sck_prev;
  logic                   sck_s;
  logic                   cs_s;
  logic [3:0]             dq_s;
  logic                   rise;
  logic                   fall;

  // cs_n chain resets low so a pin still held low after reset is never taken as a new select
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync <= '0;
      cs_sync  <= '0;
      sck_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) dq_sync[i] <= 4'h0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], qspi_sck};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], qspi_cs_n};
      dq_sync[0] <= qspi_dq_in;
      for (int i = 1; i < SYNC_STAGES; i++) dq_sync[i] <= dq_sync[i-1];
      sck_prev   <= sck_s;
    end
  end

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign dq_s  = dq_sync[SYNC_STAGES-1];
  assign rise  = sck_s & ~sck_prev;
  assign fall  = ~sck_s & sck_prev;

  state_t      state, state_n;
  logic [1:0]  nib_cnt, nib_cnt_n;
  logic [11:0] shift_word, shift_n;
  logic [14:0] addr, addr_n;
  logic [7:0]  dummy_cnt, dummy_n;
  logic [7:0]  prefetch, prefetch_n;
  logic        pf_valid, pf_valid_n;
  logic        pending, pending_n;
  logic [3:0]  cur_lo, cur_lo_n;
  logic        hi_next, hi_next_n;
  logic        armed, armed_n;
  logic [3:0]  dq_out_n;
  logic        dq_oe_n;
  logic        rd_en_n;
  logic [15:0] rd_addr_n;
  logic        wr_en_n;
  logic [15:0] wr_addr_n;
  logic [7:0]  wr_data_n;
  logic        underrun_n;
  logic        drive_hi;
  logic        resp_now;
  logic        byte_avail;
  logic [7:0]  byte_val;
  logic [15:0] word;

  assign word       = {shift_word, dq_s};
  assign resp_now   = rd_valid & pending;
  assign byte_avail = pf_valid | resp_now;
  assign byte_val   = pf_valid ? prefetch : rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      nib_cnt       <= 2'd0;
      shift_word    <= 12'h0;
      addr          <= 15'h0;
      dummy_cnt     <= 8'h0;
      prefetch      <= 8'h0;
      pf_valid      <= 1'b0;
      pending       <= 1'b0;
      cur_lo        <= 4'h0;
      hi_next       <= 1'b0;
      armed         <= 1'b0;
      qspi_dq_out   <= 4'h0;
      qspi_dq_oe    <= 1'b0;
      rd_en         <= 1'b0;
      rd_addr       <= 16'h0;
      wr_en         <= 1'b0;
      wr_addr       <= 16'h0;
      wr_data       <= 8'h0;
      read_underrun <= 1'b0;
    end else begin
      state         <= state_n;
      nib_cnt       <= nib_cnt_n;
      shift_word    <= shift_n;
      addr          <= addr_n;
      dummy_cnt     <= dummy_n;
      prefetch      <= prefetch_n;
      pf_valid      <= pf_valid_n;
      pending       <= pending_n;
      cur_lo        <= cur_lo_n;
      hi_next       <= hi_next_n;
      armed         <= armed_n;
      qspi_dq_out   <= dq_out_n;
      qspi_dq_oe    <= dq_oe_n;
      rd_en         <= rd_en_n;
      rd_addr       <= rd_addr_n;
      wr_en         <= wr_en_n;
      wr_addr       <= wr_addr_n;
      wr_data       <= wr_data_n;
      read_underrun <= underrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    nib_cnt_n  = nib_cnt;
    shift_n    = shift_word;
    addr_n     = addr;
    dummy_n    = dummy_cnt;
    prefetch_n = prefetch;
    pf_valid_n = pf_valid;
    pending_n  = pending;
    cur_lo_n   = cur_lo;
    hi_next_n  = hi_next;
    armed_n    = armed | cs_s;
    dq_out_n   = qspi_dq_out;
    dq_oe_n    = qspi_dq_oe;
    rd_en_n    = 1'b0;
    rd_addr_n  = rd_addr;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    underrun_n = 1'b0;
    drive_hi   = 1'b0;

    if (resp_now) begin
      prefetch_n = rd_data;
      pf_valid_n = 1'b1;
      pending_n  = 1'b0;
    end

    // A deselect wins over any SCK edge seen in the same cycle
    if (cs_s) begin
      state_n    = IDLE;
      nib_cnt_n  = 2'd0;
      dq_oe_n    = 1'b0;
      dq_out_n   = 4'h0;
      pending_n  = 1'b0;
      pf_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (armed) begin
            state_n   = ADDR;
            nib_cnt_n = 2'd0;
          end
        end
        ADDR: begin
          if (rise) begin
            shift_n   = {shift_word[7:0], dq_s};
            nib_cnt_n = nib_cnt + 2'd1;
            if (nib_cnt == 2'd3) begin
              addr_n = word[14:0];
              if (word[15]) begin
                rd_en_n    = 1'b1;
                rd_addr_n  = {1'b0, word[14:0]};
                pending_n  = 1'b1;
                pf_valid_n = 1'b0;
                dummy_n    = 8'h0;
                state_n    = DUMMY;
              end else begin
                nib_cnt_n = 2'd0;
                state_n   = WRITE_DATA;
              end
            end
          end
        end
        WRITE_DATA: begin
          if (rise) begin
            shift_n = {shift_word[7:0], dq_s};
            if (nib_cnt[0]) begin
              wr_en_n   = 1'b1;
              wr_addr_n = {1'b0, addr};
              wr_data_n = {shift_word[3:0], dq_s};
              addr_n    = addr + 15'd1;
              nib_cnt_n = 2'd0;
            end else begin
              nib_cnt_n = 2'd1;
            end
          end
        end
        DUMMY: begin
          if (rise && dummy_cnt != DUMMY_LAST) begin
            dummy_n = dummy_cnt + 8'd1;
          end else if (fall && dummy_cnt == DUMMY_LAST) begin
            drive_hi = 1'b1;
            dq_oe_n  = 1'b1;
            state_n  = READ_DATA;
          end
        end
        READ_DATA: begin
          if (fall) begin
            if (hi_next) begin
              drive_hi = 1'b1;
            end else begin
              dq_out_n  = cur_lo;
              hi_next_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase

      // Driving a high nibble consumes the prefetched byte and requests the following one
      if (drive_hi) begin
        if (byte_avail) begin
          dq_out_n = byte_val[7:4];
          cur_lo_n = byte_val[3:0];
        end else begin
          dq_out_n   = 4'h0;
          cur_lo_n   = 4'h0;
          underrun_n = 1'b1;
        end
        pf_valid_n = 1'b0;
        pending_n  = 1'b1;
        rd_en_n    = 1'b1;
        rd_addr_n  = {1'b0, 15'(addr + 15'd1)};
        addr_n     = addr + 15'd1;
        hi_next_n  = 1'b0;
      end
    end
  end

endmodule
